// File: rtl/video_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_pkg                                                                  |
// | Shared display timing defaults, coordinate widths and flag bundle type.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package video_pkg;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 13;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 29;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int ROW_W = 9;
  localparam int COL_W = 10;
  localparam int HC_W  = 11;
  localparam int VC_W  = 10;

  localparam int ADDR_PIPE_DLY = 2;

  typedef struct packed {
    logic sof;
    logic vsync;
    logic hsync;
    logic de;
  } sync_flags_t;

endpackage
`default_nettype wire

// File: rtl/sig_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sig_delay                                                                  |
// | Fixed-depth shift register with async active-low reset to RST_VAL.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sig_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else begin
          r_stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/raster_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | raster_gen                                                                 |
// | Raster scan counters producing row/col plus aligned de/sync/sof flags.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module raster_gen
  import video_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIPE_DLY = ADDR_PIPE_DLY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             de_d,
  output logic             hsync_d,
  output logic             vsync_d,
  output logic             sof_d
);

  localparam int c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_hs_start = H_ACTIVE + H_FP;
  localparam int c_hs_end   = H_ACTIVE + H_FP + H_SYNC;
  localparam int c_vs_start = V_ACTIVE + V_FP;
  localparam int c_vs_end   = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [3:0] c_flags_rst = {1'b0, ~SYNC_POL, ~SYNC_POL, 1'b0};

  generate
    if (H_ACTIVE > 2**COL_W || V_ACTIVE > 2**ROW_W) begin : g_chk_coord
      $error("raster_gen: active area exceeds row/col width");
    end
    if (c_h_total > 2**HC_W || c_v_total > 2**VC_W) begin : g_chk_total
      $error("raster_gen: total timing exceeds counter width");
    end
  endgenerate

  logic [HC_W-1:0] r_hc;
  logic [VC_W-1:0] r_vc;
  logic [31:0]     w_hc32;
  logic [31:0]     w_vc32;
  logic            w_h_last;
  logic            w_v_last;
  logic            w_h_act;
  logic            w_v_act;
  logic            w_hs_in;
  logic            w_vs_in;
  sync_flags_t     w_flags;
  sync_flags_t     w_flags_d;

  assign w_h_last = (r_hc == HC_W'(c_h_total - 1));
  assign w_v_last = (r_vc == VC_W'(c_v_total - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (en) begin
      if (w_h_last) begin
        r_hc <= '0;
        r_vc <= w_v_last ? '0 : r_vc + 1'b1;
      end else begin
        r_hc <= r_hc + 1'b1;
      end
    end
  end

  assign w_hc32  = 32'(r_hc);
  assign w_vc32  = 32'(r_vc);
  assign w_h_act = (w_hc32 < H_ACTIVE);
  assign w_v_act = (w_vc32 < V_ACTIVE);
  assign w_hs_in = (w_hc32 >= c_hs_start) && (w_hc32 < c_hs_end);
  assign w_vs_in = (w_vc32 >= c_vs_start) && (w_vc32 < c_vs_end);

  assign w_flags.de    = w_h_act && w_v_act;
  assign w_flags.hsync = w_hs_in ? SYNC_POL : ~SYNC_POL;
  assign w_flags.vsync = w_vs_in ? SYNC_POL : ~SYNC_POL;
  assign w_flags.sof   = (r_hc == '0) && (r_vc == '0) && en;

  // Blanking coordinates are forced to 0 so the address stage stays in range
  assign col = w_h_act ? r_hc[COL_W-1:0] : '0;
  assign row = w_v_act ? r_vc[ROW_W-1:0] : '0;

  sig_delay #(
    .WIDTH   (4),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (c_flags_rst)
  ) u_flag_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (w_flags),
    .q     (w_flags_d)
  );

  assign de_d    = w_flags_d.de;
  assign hsync_d = w_flags_d.hsync;
  assign vsync_d = w_flags_d.vsync;
  assign sof_d   = w_flags_d.sof;

endmodule
`default_nettype wire

// File: tb/tb_raster_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_raster_gen                                                              |
// | Default-timing and reduced-timing raster_gen against a linear-position    |
// | reference model. Revision: 1.0                                             |
// +----------------------------------------------------------------------------+
module tb_raster_gen;

  typedef struct packed {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
    int pol; int dly;
  } tim_t;

  localparam tim_t TA = '{ha:800, hfp:40, hs:128, hbp:88, va:480, vfp:13, vs:3, vbp:29, pol:0, dly:2};
  localparam tim_t TB = '{ha:16, hfp:2, hs:3, hbp:3, va:6, vfp:1, vs:2, vbp:1, pol:1, dly:3};

  logic clk, rst_n, en, cmp_on;
  logic [8:0] row_a, row_b;
  logic [9:0] col_a, col_b;
  logic de_d_a, hsync_d_a, vsync_d_a, sof_d_a;
  logic de_d_b, hsync_d_b, vsync_d_b, sof_d_b;
  int checks, failures;

  raster_gen dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .row(row_a), .col(col_a),
    .de_d(de_d_a), .hsync_d(hsync_d_a), .vsync_d(vsync_d_a), .sof_d(sof_d_a)
  );

  raster_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .PIPE_DLY(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .row(row_b), .col(col_b),
    .de_d(de_d_b), .hsync_d(hsync_d_b), .vsync_d(vsync_d_b), .sof_d(sof_d_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int line_len(tim_t t);
    return t.ha + t.hfp + t.hs + t.hbp;
  endfunction

  function automatic int frame_len(tim_t t);
    return line_len(t) * (t.va + t.vfp + t.vs + t.vbp);
  endfunction

  // {sof, vsync, hsync, de} for scan position pos (pixels since frame start)
  function automatic logic [3:0] raw_flags(tim_t t, int pos, logic en_i);
    int hc, vc;
    logic hin, vin, de, sof;
    hc  = pos % line_len(t);
    vc  = pos / line_len(t);
    hin = (hc >= t.ha + t.hfp) && (hc < t.ha + t.hfp + t.hs);
    vin = (vc >= t.va + t.vfp) && (vc < t.va + t.vfp + t.vs);
    de  = (hc < t.ha) && (vc < t.va);
    sof = (pos == 0) && en_i;
    return {sof, vin ? t.pol[0] : ~t.pol[0], hin ? t.pol[0] : ~t.pol[0], de};
  endfunction

  function automatic logic [3:0] idle_flags(tim_t t);
    return {1'b0, ~t.pol[0], ~t.pol[0], 1'b0};
  endfunction

  function automatic logic [22:0] expect_vec(tim_t t, int pos, logic [3:0] dly);
    int hc, vc, r, c;
    hc = pos % line_len(t);
    vc = pos / line_len(t);
    r  = (vc < t.va) ? vc : 0;
    c  = (hc < t.ha) ? hc : 0;
    return {9'(r), 10'(c), dly};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s at %0t: actual=0x%0h expected=0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: linear scan position plus a history of flag vectors
  int pos_a, pos_b;
  logic [3:0] hist_a [8];
  logic [3:0] hist_b [8];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_a <= 0;
      pos_b <= 0;
      for (int i = 0; i < 8; i++) begin
        hist_a[i] <= idle_flags(TA);
        hist_b[i] <= idle_flags(TB);
      end
    end else begin
      hist_a[0] <= raw_flags(TA, pos_a, en);
      hist_b[0] <= raw_flags(TB, pos_b, en);
      for (int i = 1; i < 8; i++) begin
        hist_a[i] <= hist_a[i-1];
        hist_b[i] <= hist_b[i-1];
      end
      if (en) begin
        pos_a <= (pos_a + 1) % frame_len(TA);
        pos_b <= (pos_b + 1) % frame_len(TB);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("scan_a", {row_a, col_a, sof_d_a, vsync_d_a, hsync_d_a, de_d_a},
            expect_vec(TA, pos_a, hist_a[TA.dly-1]));
      check("scan_b", {row_b, col_b, sof_d_b, vsync_d_b, hsync_d_b, de_d_b},
            expect_vec(TB, pos_b, hist_b[TB.dly-1]));
    end
  end

  int n_de_a, n_hs_a, n_vs_a, n_de_b, n_vs_b, n_hs_b, n_sof_b;

  initial begin
    rst_n = 1'b0; en = 1'b0; cmp_on = 1'b0;
    checks = 0; failures = 0;
    n_de_a = 0; n_hs_a = 0; n_vs_a = 0;
    n_de_b = 0; n_vs_b = 0; n_hs_b = 0; n_sof_b = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_row_a", row_a, 0);
    check("rst_col_a", col_a, 0);
    check("rst_flags_a", {sof_d_a, vsync_d_a, hsync_d_a, de_d_a}, 4'b0110);
    check("rst_flags_b", {sof_d_b, vsync_d_b, hsync_d_b, de_d_b}, 4'b0000);
    cmp_on = 1'b1;
    rst_n  = 1'b1;
    en     = 1'b1;

    // Continuous enable: first frame start, line and frame flag counts
    for (int k = 1; k <= 3200; k++) begin
      @(negedge clk);
      if (k == 1) check("sof_a_clk1", sof_d_a, 0);
      if (k == 2) check("sof_a_clk2", sof_d_a, 1);
      if (k == 3) check("sof_a_clk3", sof_d_a, 0);
      if (k == 2) check("sof_b_clk2", sof_d_b, 0);
      if (k == 3) check("sof_b_clk3", sof_d_b, 1);
      if (k >= 2 && k <= 3169) begin
        n_de_a += int'(de_d_a);
        n_hs_a += int'(!hsync_d_a);
        n_vs_a += int'(!vsync_d_a);
      end
      if (k >= 3 && k <= 242) begin
        n_de_b  += int'(de_d_b);
        n_vs_b  += int'(vsync_d_b);
        n_hs_b  += int'(hsync_d_b);
        n_sof_b += int'(sof_d_b);
      end
      if (k == 243) check("sof_b_period", sof_d_b, 1);
    end
    check("de_a_3lines", n_de_a, 2400);
    check("hsync_a_3lines", n_hs_a, 384);
    check("vsync_a_3lines", n_vs_a, 0);
    check("de_b_frame", n_de_b, 96);
    check("vsync_b_frame", n_vs_b, 48);
    check("hsync_b_frame", n_hs_b, 30);
    check("sof_b_frame", n_sof_b, 1);

    // Enable pattern 1,0,0,1 at pixel (3,32)
    check("pre_hold_row", row_a, 3);
    check("pre_hold_col", col_a, 32);
    en = 1'b0;
    @(negedge clk);
    check("hold1_col", col_a, 32);
    @(negedge clk);
    check("hold2_col", col_a, 32);
    check("hold2_row", row_a, 3);
    en = 1'b1;
    @(negedge clk);
    check("resume_col", col_a, 33);

    for (int k = 0; k < 30000; k++) begin
      en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end

    // Asynchronous reset between edges, mid-frame
    en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_row_a", row_a, 0);
    check("arst_col_a", col_a, 0);
    check("arst_flags_a", {sof_d_a, vsync_d_a, hsync_d_a, de_d_a}, 4'b0110);
    check("arst_flags_b", {sof_d_b, vsync_d_b, hsync_d_b, de_d_b}, 4'b0000);
    check("arst_col_b", col_b, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) check("rel_col_a", col_a, 1);
      if (k == 2) check("rel_sof_a", sof_d_a, 1);
      if (k == 3) check("rel_sof_b", sof_d_b, 1);
    end

    for (int k = 0; k < 5000; k++) begin
      en = ($urandom_range(0, 4) != 0);
      @(negedge clk);
    end

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/raster_gen.md
# raster_gen

Raster scan generator that sits directly upstream of the frame-buffer address stage. Produces the `row`/`col` pixel coordinates for an 800×480 display, 1056×525 total timing, which the address stage turns into a byte address two clocks later. Also produces `de`, `hsync`, `vsync` and a start-of-frame pulse, delayed by the address stage's latency so they line up with the address it emits.

## Interface
- `H_ACTIVE`, 800: active pixels per line
- `H_FP`, 40 / `H_SYNC`, 128 / `H_BP`, 88: horizontal porches and sync width (H_TOTAL = 1056)
- `V_ACTIVE`, 480: active lines
- `V_FP`, 13 / `V_SYNC`, 3 / `V_BP`, 29: vertical porches and sync width (V_TOTAL = 525)
- `SYNC_POL`, 0: sync asserted level (0 = active-low)
- `PIPE_DLY`, 2: clocks of alignment delay; equals the address stage latency
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `en` in 1: pixel enable; counters advance only when 1
- `row` out 9: active line index, feeds address stage
- `col` out 10: active pixel index, feeds address stage
- `de_d` out 1: data enable, delayed by PIPE_DLY
- `hsync_d` out 1: horizontal sync, delayed by PIPE_DLY
- `vsync_d` out 1: vertical sync, delayed by PIPE_DLY
- `sof_d` out 1: one-cycle start-of-frame pulse, delayed by PIPE_DLY

## Operation
- Internal counters: `hc` is 11 bits, because 1056 > 1023. `vc` is 10 bits, because 525 > 511.
- `en`=1 behaviour:
  - `hc` increments.
  - At `hc`=H_TOTAL-1, `hc` wraps to 0 and `vc` increments.
  - At `vc`=V_TOTAL-1 with an `hc` wrap, `vc` wraps to 0.
- `en`=0: both counters hold.
- Undelayed signals are combinational from the counter registers:
  - active = (`hc` < H_ACTIVE) && (`vc` < V_ACTIVE)
  - hsync asserted for H_ACTIVE+H_FP ≤ `hc` < H_ACTIVE+H_FP+H_SYNC (840..967)
  - vsync asserted for V_ACTIVE+V_FP ≤ `vc` < V_ACTIVE+V_FP+V_SYNC (493..495)
  - sof = (`hc`==0 && `vc`==0 && `en`)
- Coordinate outputs:
  - `col` = `hc`[9:0] when `hc` < H_ACTIVE, else 0.
  - `row` = `vc`[8:0] when `vc` < V_ACTIVE, else 0.
  - Out-of-range values are never presented, so the address stage never exceeds 479·1200+1198.
- Delay lines: de/hsync/vsync/sof pass through a PIPE_DLY-deep shift register clocked every `clk`, not gated by `en`. This matches the free-running address stage.
- Reset (async assert, any time, including mid-line or mid-frame):
  - `hc`=0, `vc`=0, so `row`=0 and `col`=0.
  - All delay stages clear: `de_d`=0, `sof_d`=0, `hsync_d`=`vsync_d`=!SYNC_POL (inactive).
- Reset release: the scan restarts at (0,0). The first `sof_d` pulse follows PIPE_DLY clocks after the first clock with `en`=1.
- Holding `en`=0 for k clocks during a pixel: the outputs hold that pixel, and the delayed flags repeat it k extra clocks. This is consistent with the address stage repeating the address.

## Timing
- `row`/`col` change on the clock edge after an `en`=1 cycle, with zero added latency from the counters.
- Delayed outputs at clock t equal the undelayed values at clock t-PIPE_DLY. With PIPE_DLY=2, `de_d` is high exactly when the address stage output corresponds to an active pixel.
- Frame period with `en` tied high: 1056·525 = 554400 clocks. `sof_d` is high for exactly 1 clock per frame.
- Per line with `en`=1: `de_d` high for 800 clocks and `hsync_d` asserted for 128 clocks.
- Per frame: `vsync_d` asserted for 3 lines (3168 clocks).

## Structure
- Shared package `video_pkg` holds:
  - the default timing constants (H_/V_ active, porch, sync, totals)
  - `ROW_W`=9, `COL_W`=10
  - `ADDR_PIPE_DLY`=2
- Elaboration checks in this block:
  - H_ACTIVE ≤ 1024 and V_ACTIVE ≤ 512 (coordinate widths)
  - the totals fit the counter widths
- Sub-module `sig_delay`: parameterised width/depth shift register with async active-low reset and a per-bit reset value. Instantiated once, 4 bits wide, PIPE_DLY deep.

## Test plan
- Reset then `en`=1 continuously:
  - `sof_d` pulses at clock 2 and again at clock 554402.
  - The `de_d` count between the two pulses is 384000.
- Line wrap: sample at `hc`=799→800.
  - `col` goes 799→0 and `de` falls.
  - `de_d` falls exactly 2 clocks later.
  - At `hc`=1055→0, `row` increments.
- Sync windows, SYNC_POL=0:
  - `hsync_d` is low for exactly 128 clocks starting 2 clocks after `hc`=840.
  - `vsync_d` is low while delayed `vc` is in 493..495.
- `en` toggling 1,0,0,1:
  - `row`/`col` hold for 2 clocks.
  - `de_d` repeats the held value; no pixel is skipped or duplicated in the counter sequence.
- Async reset asserted at `vc`=200, `hc`=500 between edges:
  - Outputs go to the reset values immediately.
  - After release, the scan resumes at (0,0) and `sof_d` follows 2 clocks later.
- Blanking coordinates: for the entire vertical blank (`vc` 480..524), `row`=0 and `de_d`=0.
